// File: rtl/traceback_ctrl.sv
// Traceback sequencer for the rate-1/2, K=3 Viterbi decoder: walks survivor
// decisions backwards from an end state, then streams decoded bits in forward order.
module traceback_ctrl #(
  parameter int ADDR_W = 3,
  parameter int NS_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st,
  input  logic [NS_W-1:0]      start_node,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [2**NS_W-1:0]   mem_data,
  output logic                 dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int TB_LEN = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TB_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACE = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        state;
  logic [NS_W-1:0]   node;
  logic [TB_LEN-1:0] bits_q;
  logic              rd_q;    // mem_data for addr_q is valid this cycle
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] idx;

  // NOTE: the bit buffer is only TB_LEN flops, so it is reset along with the
  // control state; larger memories would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      node       <= '0;
      bits_q     <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      idx        <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (st) begin
            node     <= start_node;
            mem_addr <= LAST;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_TRACE;
          end
        end

        S_TRACE: begin
          rd_q   <= mem_rd;
          addr_q <= mem_addr;
          // Address side runs one cycle ahead of the data side and stops at 0.
          if (mem_rd) begin
            if (mem_addr == '0) mem_rd   <= 1'b0;
            else                mem_addr <= mem_addr - 1'b1;
          end
          if (rd_q) begin
            bits_q[addr_q] <= node[NS_W-1];
            node           <= {node[0], mem_data[node]};
            if (addr_q == '0) begin
              // bits_q[0] is being written now, so present it straight from node.
              idx        <= '0;
              dout       <= node[NS_W-1];
              dout_valid <= 1'b1;
              state      <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (dout_valid && dout_ready) begin
            if (idx == LAST) begin
              dout       <= 1'b0;
              dout_valid <= 1'b0;
              done       <= 1'b1;
              state      <= S_FIN;
            end else begin
              idx  <= idx + 1'b1;
              dout <= bits_q[idx + 1'b1];
            end
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_ctrl.sv
// Directed bench for traceback_ctrl: behavioural survivor memory, hand-derived
// decoded sequences, handshake stalls, ignored starts and mid-run reset.
module tb_traceback_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st = 1'b0;
  logic [1:0] start_node = 2'b00;
  logic       mem_rd;
  logic [2:0] mem_addr;
  logic [3:0] mem_data = 4'b0000;
  logic       dout;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic       busy;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  logic [3:0] mem_arr [8];

  traceback_ctrl #(.ADDR_W(3), .NS_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .st         (st),
    .start_node (start_node),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read survivor memory; garbage when not read.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem_arr[mem_addr];
    else        mem_data <= 4'($urandom);
  end

  task automatic fill_mem(input logic [3:0] v);
    for (int i = 0; i < 8; i++) mem_arr[i] = v;
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if ({mem_rd, mem_addr, dout, dout_valid, busy, done} !== 8'b0) begin
      errors++;
      $display("FAIL %s: rd=%b addr=%0d dout=%b vld=%b busy=%b done=%b, required all 0",
               name, mem_rd, mem_addr, dout, dout_valid, busy, done);
    end
  endtask

  // Accept a start, check the address walk and output latency.
  task automatic launch(input logic [1:0] node, input bit pulse_st);
    int lat;
    @(negedge clk);
    st = 1'b1; start_node = node;
    @(negedge clk);
    st = 1'b0; start_node = ~node;
    vectors++;
    if (!(mem_rd === 1'b1 && mem_addr === 3'd7 && busy === 1'b1)) begin
      errors++;
      $display("FAIL launch_e0: rd=%b addr=%0d busy=%b, required 1 7 1", mem_rd, mem_addr, busy);
    end
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      lat++;
      if (pulse_st) begin
        st = (k == 3);
        start_node = 2'b01;
      end
      vectors++;
      if (k < 8) begin
        if (!(mem_rd === 1'b1 && mem_addr === 3'(7 - k))) begin
          errors++;
          $display("FAIL addr_walk k=%0d: rd=%b addr=%0d, required 1 %0d", k, mem_rd, mem_addr, 7 - k);
        end
      end else if (mem_rd !== 1'b0 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd_stop: rd=%b vld=%b, required 0 0", mem_rd, dout_valid);
      end
    end
    st = 1'b0;
    @(negedge clk);
    lat++;
    vectors++;
    if (dout_valid !== 1'b1 || lat != 9) begin
      errors++;
      $display("FAIL latency: vld=%b after %0d cycles, required 1 after 9", dout_valid, lat);
    end
  endtask

  // Drain TB_LEN bits; optional 3-cycle stall and st pulse at given indices.
  task automatic collect(input string name, input logic [7:0] exp,
                         input int stall_idx, input int pulse_idx);
    int idx = 0;
    int guard = 0;
    dout_ready = 1'b1;
    while (idx < 8 && guard < 200) begin
      if (dout_valid === 1'b1) begin
        vectors++;
        if (dout !== exp[idx]) begin
          errors++;
          $display("FAIL %s bit%0d: got %b, required %b", name, idx, dout, exp[idx]);
        end
        if (idx == stall_idx) begin
          dout_ready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            vectors++;
            if (dout_valid !== 1'b1 || dout !== exp[idx]) begin
              errors++;
              $display("FAIL %s stall bit%0d: vld=%b dout=%b, required 1 %b",
                       name, idx, dout_valid, dout, exp[idx]);
            end
          end
          dout_ready = 1'b1;
        end
        if (idx == pulse_idx) begin
          st = 1'b1; start_node = 2'b11;
        end
        idx++;
      end
      @(negedge clk);
      st = 1'b0;
      guard++;
    end
    vectors++;
    if (idx != 8) begin
      errors++;
      $display("FAIL %s timeout: %0d bits received, required 8", name, idx);
    end
    vectors++;
    if (done !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b vld=%b, required 1 0", name, done, dout_valid);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    #2 check_idle("reset_initial");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_after_reset");
  endtask

  task automatic test_zero_node10;
    fill_mem(4'b0000);
    launch(2'b10, 1'b0);
    collect("zero_n10", 8'b1000_0000, -1, -1);
  endtask

  task automatic test_ones_node11;
    fill_mem(4'b1111);
    launch(2'b11, 1'b0);
    collect("ones_n11", 8'b1111_1111, -1, -1);
  endtask

  task automatic test_stall_node01;
    fill_mem(4'b0000);
    launch(2'b01, 1'b0);
    collect("stall_n01", 8'b0100_0000, 3, -1);
  endtask

  task automatic test_mixed;
    mem_arr[7] = 4'b0111; mem_arr[6] = 4'b0100; mem_arr[5] = 4'b0001; mem_arr[4] = 4'b1011;
    mem_arr[3] = 4'b0001; mem_arr[2] = 4'b0010; mem_arr[1] = 4'b1000; mem_arr[0] = 4'b0000;
    launch(2'b11, 1'b0);
    collect("mixed_n11", 8'b1101_0011, -1, -1);
  endtask

  task automatic test_ignore_st;
    int extra = 0;
    fill_mem(4'b0000);
    launch(2'b10, 1'b1);
    collect("ignore_st", 8'b1000_0000, -1, 4);
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_st_queue: %0d cycles busy/done after job, required 0", extra);
    end
  endtask

  task automatic test_abort;
    int dones = 0;
    fill_mem(4'b1111);
    @(negedge clk);
    st = 1'b1; start_node = 2'b11;
    @(negedge clk);
    st = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle("abort_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: %0d done pulses busy=%b, required 0 0", dones, busy);
    end
    fill_mem(4'b0000);
    launch(2'b10, 1'b0);
    collect("after_abort", 8'b1000_0000, -1, -1);
  endtask

  initial begin
    test_reset();
    test_zero_node10();
    test_ones_node11();
    test_stall_node01();
    test_mixed();
    test_ignore_st();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
